// File: rtl/accumulator_dump_if.sv
// accumulator_dump_if: sample-in / window-sum-out handshake bundle for accumulator_dump.
interface accumulator_dump_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24
) ();
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 clear;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_overflow;

    modport master (
        output in_data, in_valid, clear, out_ready,
        input  in_ready, out_data, out_valid, out_overflow
    );

    modport slave (
        input  in_data, in_valid, clear, out_ready,
        output in_ready, out_data, out_valid, out_overflow
    );
endinterface

// File: rtl/accumulator_dump.sv
// accumulator_dump: integrate-and-dump of SAMPLES words with wrap/saturate and overflow flag.
// Optional ACCUMULATOR_DUMP_PEEK_EN exposes the partial acc and count as outputs.
module accumulator_dump #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24,
    parameter int SAMPLES   = 4,
    parameter int SATURATE  = 0
) (
    input logic clk,
    input logic reset,
    accumulator_dump_if.slave bus
`ifdef ACCUMULATOR_DUMP_PEEK_EN
    ,
    output logic [ACC_WIDTH-1:0]            acc_peek,
    output logic [$clog2(SAMPLES+1)-1:0]    count_peek
`endif
);
    localparam int CW = $clog2(SAMPLES + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] f;
    logic                 carry, accept, dump, take, in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ACCUM && dump)
            state_d = HOLD;
        else if (state_q == HOLD && take)
            state_d = ACCUM;
    end

    always_comb begin
        in_ready = (state_q == ACCUM) && !bus.clear && !reset;
    end

    // Carry is bit ACC_WIDTH of the widened add; a saturated acc stays at all-ones.
    always_comb begin
        sum         = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.in_data);
        carry       = sum[ACC_WIDTH];
        f           = (SATURATE != 0 && carry) ? '1 : sum[ACC_WIDTH-1:0];
        accept      = bus.in_valid && in_ready;
        dump        = accept && (count_q == CW'(SAMPLES - 1));
        take        = out_valid_q && bus.out_ready;
        acc_d       = (bus.clear || dump) ? '0 : accept ? f : acc_q;
        count_d     = (bus.clear || dump) ? '0 : accept ? count_q + CW'(1) : count_q;
        ovf_d       = (bus.clear || dump) ? 1'b0 : accept ? (ovf_q | carry) : ovf_q;
        out_data_d  = dump ? f : out_data_q;
        out_valid_d = dump ? 1'b1 : take ? 1'b0 : out_valid_q;
        out_ovf_d   = dump ? (ovf_q | carry) : take ? 1'b0 : out_ovf_q;
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_overflow = out_ovf_q;

`ifdef ACCUMULATOR_DUMP_PEEK_EN
    assign acc_peek   = acc_q;
    assign count_peek = count_q;
`endif
endmodule

// File: tb/tb_accumulator_dump.sv
// tb_accumulator_dump: directed vectors for default, 16-bit wrap, 16-bit saturate and SAMPLES=1 builds.
module tb_accumulator_dump;
    logic clk = 1'b0;
    logic reset;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    accumulator_dump_if #(.IN_WIDTH(16), .ACC_WIDTH(24)) a ();
    accumulator_dump_if #(.IN_WIDTH(16), .ACC_WIDTH(16)) w ();
    accumulator_dump_if #(.IN_WIDTH(16), .ACC_WIDTH(16)) s ();
    accumulator_dump_if #(.IN_WIDTH(16), .ACC_WIDTH(24)) o ();

`ifdef ACCUMULATOR_DUMP_PEEK_EN
    logic [23:0] a_acc, o_acc;
    logic [15:0] w_acc, s_acc;
    logic [2:0]  a_cnt, w_cnt, s_cnt;
    logic [0:0]  o_cnt;
`endif

    accumulator_dump #(.IN_WIDTH(16), .ACC_WIDTH(24), .SAMPLES(4), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .bus(a)
`ifdef ACCUMULATOR_DUMP_PEEK_EN
        , .acc_peek(a_acc), .count_peek(a_cnt)
`endif
    );
    accumulator_dump #(.IN_WIDTH(16), .ACC_WIDTH(16), .SAMPLES(4), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .bus(w)
`ifdef ACCUMULATOR_DUMP_PEEK_EN
        , .acc_peek(w_acc), .count_peek(w_cnt)
`endif
    );
    accumulator_dump #(.IN_WIDTH(16), .ACC_WIDTH(16), .SAMPLES(4), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .bus(s)
`ifdef ACCUMULATOR_DUMP_PEEK_EN
        , .acc_peek(s_acc), .count_peek(s_cnt)
`endif
    );
    accumulator_dump #(.IN_WIDTH(16), .ACC_WIDTH(24), .SAMPLES(1), .SATURATE(0)) dut_o (
        .clk(clk), .reset(reset), .bus(o)
`ifdef ACCUMULATOR_DUMP_PEEK_EN
        , .acc_peek(o_acc), .count_peek(o_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic win_a(input logic [15:0] d0, d1, d2, d3);
        a.in_valid = 1'b1;
        a.in_data = d0; step;
        a.in_data = d1; step;
        a.in_data = d2; step;
        a.in_data = d3; step;
        a.in_valid = 1'b0;
    endtask

    task automatic win_ws(input logic [15:0] d0, d1, d2, d3);
        w.in_valid = 1'b1; s.in_valid = 1'b1;
        w.in_data = d0; s.in_data = d0; step;
        w.in_data = d1; s.in_data = d1; step;
        w.in_data = d2; s.in_data = d2; step;
        w.in_data = d3; s.in_data = d3; step;
        w.in_valid = 1'b0; s.in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {a.in_data, a.in_valid, a.clear} = '0; a.out_ready = 1'b1;
        {w.in_data, w.in_valid, w.clear} = '0; w.out_ready = 1'b1;
        {s.in_data, s.in_valid, s.clear} = '0; s.out_ready = 1'b1;
        {o.in_data, o.in_valid, o.clear} = '0; o.out_ready = 1'b1;
        step; step;
        chk("rst_valid", a.out_valid, 0);
        chk("rst_data", a.out_data, 0);
        chk("rst_ovf", a.out_overflow, 0);
        chk("rst_in_ready", a.in_ready, 0);
        reset = 1'b0;
        #1 chk("post_rst_in_ready", a.in_ready, 1);

        // 5,5,5,5 -> 20, valid one cycle after the 4th accept
        a.in_valid = 1'b1; a.in_data = 16'd5;
        step; step; step;
        chk("t1_not_yet", a.out_valid, 0);
        step;
        a.in_valid = 1'b0;
        chk("t1_valid", a.out_valid, 1);
        chk("t1_data", a.out_data, 20);
        chk("t1_ovf", a.out_overflow, 0);
        chk("t1_hold_ready", a.in_ready, 0);
        step;
        chk("t1_valid_drop", a.out_valid, 0);
        chk("t1_ready_back", a.in_ready, 1);

        // backpressure holds 10 while in_valid is ignored
        a.out_ready = 1'b0;
        win_a(1, 2, 3, 4);
        a.in_valid = 1'b1; a.in_data = 16'd99;
        for (int i = 0; i < 3; i++) begin
            chk("t2_bp_valid", a.out_valid, 1);
            chk("t2_bp_data", a.out_data, 10);
            chk("t2_bp_ready", a.in_ready, 0);
            step;
        end
        a.in_valid = 1'b0; a.out_ready = 1'b1;
        step;
        chk("t2_release_valid", a.out_valid, 0);
        chk("t2_release_ready", a.in_ready, 1);

        // 16-bit wrap vs saturate, then a clean window clears the flag
        win_ws(16'hFFFF, 16'h0002, 0, 0);
        chk("t3_wrap_data", w.out_data, 32'h0001);
        chk("t3_wrap_ovf", w.out_overflow, 1);
        chk("t4_sat_data", s.out_data, 32'hFFFF);
        chk("t4_sat_ovf", s.out_overflow, 1);
        step;
        win_ws(1, 1, 1, 1);
        chk("t3_wrap_next", w.out_data, 4);
        chk("t3_wrap_next_ovf", w.out_overflow, 0);
        chk("t4_sat_next", s.out_data, 4);
        chk("t4_sat_next_ovf", s.out_overflow, 0);
        step;

        // clear aborts 7,7 and blocks the concurrent 9
        a.in_valid = 1'b1; a.in_data = 16'd7;
        step; step;
        a.in_data = 16'd9; a.clear = 1'b1;
        #1 chk("t5_clear_ready", a.in_ready, 0);
        step;
        a.clear = 1'b0; a.in_valid = 1'b0;
        win_a(1, 1, 1, 1);
        chk("t5_after_clear", a.out_data, 4);
        chk("t5_after_clear_valid", a.out_valid, 1);
        step;

        // SAMPLES=1: every accept dumps
        o.in_valid = 1'b1; o.in_data = 16'hABCD;
        #1 chk("s1_ready", o.in_ready, 1);
        step;
        chk("s1_valid", o.out_valid, 1);
        chk("s1_data", o.out_data, 32'hABCD);
        chk("s1_hold_ready", o.in_ready, 0);
        o.in_data = 16'h0001;
        step;
        chk("s1_drop", o.out_valid, 0);
        step;
        chk("s1_data2", o.out_data, 1);
        o.in_valid = 1'b0;
        step;

        // reset during a stalled HOLD drops the pending output
        a.out_ready = 1'b0;
        win_a(3, 3, 3, 3);
        chk("t6_pending", a.out_data, 12);
        reset = 1'b1;
        step;
        chk("t6_rst_valid", a.out_valid, 0);
        chk("t6_rst_data", a.out_data, 0);
        reset = 1'b0;
        #1 chk("t6_rst_ready", a.in_ready, 1);
        a.out_ready = 1'b1;
        win_a(2, 2, 2, 2);
        chk("t6_after", a.out_data, 8);
        step;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
